// File: rtl/elliptic_curve_structs.sv
// Shared curve types and helpers for the MSM datapath: point layout, infinity encoding, widths.
package elliptic_curve_structs;

    localparam int unsigned P_WIDTH      = 377;
    localparam int unsigned SCALAR_WIDTH = 254;

    // Affine point; (0,0) is not on the curve (b=1) and stands for infinity.
    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    localparam curve_point_t inf_point = '0;

    // Single infinity test shared by every block that consumes points.
    function automatic logic is_inf(input curve_point_t p);
        return (p.x == '0) && (p.y == '0);
    endfunction

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Double-and-add sequencer: walks k MSB-first and schedules doublings/additions
// onto one shared external point-add unit, short-circuiting infinity operands.
module scalar_mult_ctrl
    import elliptic_curve_structs::curve_point_t;
    import elliptic_curve_structs::inf_point;
    import elliptic_curve_structs::is_inf;
#(
    parameter int unsigned SCALAR_WIDTH = elliptic_curve_structs::SCALAR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [SCALAR_WIDTH-1:0] scalar,
    input  curve_point_t            point,
    output logic                    done_valid,
    input  logic                    done_ready,
    output curve_point_t            result,
    output logic                    add_req_valid,
    input  logic                    add_req_ready,
    output curve_point_t            add_op_a,
    output curve_point_t            add_op_b,
    input  logic                    add_rsp_valid,
    input  curve_point_t            add_rsp_point,
    output logic [9:0]              ops_issued,
    output logic                    busy
);

    localparam int unsigned IDX_W = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;
    localparam int unsigned OPS_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DBL,
        S_DBL_WAIT,
        S_ADD,
        S_ADD_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [SCALAR_WIDTH-1:0] scalar_q;
    curve_point_t            point_q;
    curve_point_t            acc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [OPS_W-1:0]        ops_q;
    logic                    start_ready_q;
    logic                    busy_q;
    logic                    done_valid_q;
    curve_point_t            result_q;
    logic                    req_valid_q;
    curve_point_t            op_a_q;
    curve_point_t            op_b_q;

    // Scalar bit under consideration for the current iteration.
    logic bit_c;
    assign bit_c = scalar_q[idx_q];

    // Sequencer. The add request is raised on entry to DBL/ADD so a skipped bit
    // costs exactly one cycle per state; operands only change on entry, which
    // keeps them stable for the whole request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            scalar_q      <= '0;
            point_q       <= inf_point;
            acc_q         <= inf_point;
            idx_q         <= '0;
            ops_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            result_q      <= inf_point;
            req_valid_q   <= 1'b0;
            op_a_q        <= inf_point;
            op_b_q        <= inf_point;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        scalar_q      <= scalar;
                        point_q       <= point;
                        acc_q         <= inf_point;
                        idx_q         <= IDX_W'(SCALAR_WIDTH - 1);
                        ops_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_DBL;
                    end
                end
                S_DBL: begin
                    if (!req_valid_q) begin
                        // acc is infinity: doubling is a no-op, and so is an add request
                        state_q <= S_ADD;
                    end else if (add_req_ready) begin
                        req_valid_q <= 1'b0;
                        ops_q       <= ops_q + OPS_W'(1);
                        state_q     <= S_DBL_WAIT;
                    end
                end
                S_DBL_WAIT: begin
                    if (add_rsp_valid) begin
                        acc_q       <= add_rsp_point;
                        req_valid_q <= bit_c && !is_inf(add_rsp_point);
                        op_a_q      <= add_rsp_point;
                        op_b_q      <= point_q;
                        state_q     <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (!bit_c) begin
                        state_q <= S_NEXT;
                    end else if (is_inf(acc_q)) begin
                        acc_q   <= point_q;
                        state_q <= S_NEXT;
                    end else if (add_req_ready) begin
                        req_valid_q <= 1'b0;
                        ops_q       <= ops_q + OPS_W'(1);
                        state_q     <= S_ADD_WAIT;
                    end
                end
                S_ADD_WAIT: begin
                    if (add_rsp_valid) begin
                        acc_q   <= add_rsp_point;
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx_q == '0) begin
                        done_valid_q <= 1'b1;
                        result_q     <= acc_q;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q       <= idx_q - IDX_W'(1);
                        req_valid_q <= !is_inf(acc_q);
                        op_a_q      <= acc_q;
                        op_b_q      <= acc_q;
                        state_q     <= S_DBL;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        done_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready   = start_ready_q;
    assign busy          = busy_q;
    assign done_valid    = done_valid_q;
    assign result        = result_q;
    assign add_req_valid = req_valid_q;
    assign add_op_a      = op_a_q;
    assign add_op_b      = op_b_q;
    assign ops_issued    = ops_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: a point-add unit model over an abstract cyclic group
// (m·G encoded as x=m, y=1; m=0 is infinity) lets k·G be predicted as k*g mod 2^64.
module tb_scalar_mult_ctrl;
    import elliptic_curve_structs::*;

    localparam int unsigned SW  = SCALAR_WIDTH;
    localparam int unsigned CW  = 2 * P_WIDTH;
    localparam int unsigned LAT = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [SW-1:0] scalar;
    curve_point_t  point;
    logic          done_valid;
    logic          done_ready;
    curve_point_t  result;
    logic          add_req_valid;
    logic          add_req_ready;
    curve_point_t  add_op_a;
    curve_point_t  add_op_b;
    logic          add_rsp_valid;
    curve_point_t  add_rsp_point;
    logic [9:0]    ops_issued;
    logic          busy;

    always #5 clk = ~clk;

    scalar_mult_ctrl #(.SCALAR_WIDTH(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .scalar       (scalar),
        .point        (point),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .result       (result),
        .add_req_valid(add_req_valid),
        .add_req_ready(add_req_ready),
        .add_op_a     (add_op_a),
        .add_op_b     (add_op_b),
        .add_rsp_valid(add_rsp_valid),
        .add_rsp_point(add_rsp_point),
        .ops_issued   (ops_issued),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    int cyc       = 0;
    int start_cyc = 0;
    int valid_cycles;
    int stall_cnt = 0;
    logic force_neg = 1'b0;
    logic [63:0] g_m;
    curve_point_t g_pt;

    curve_point_t log_a[$];
    curve_point_t log_b[$];
    curve_point_t rsp_q[$];
    int           due_q[$];

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic curve_point_t enc(input logic [63:0] m);
        curve_point_t p;
        p = inf_point;
        if (m != 64'd0) begin
            p.x = P_WIDTH'(m);
            p.y = P_WIDTH'(64'd1);
        end
        return p;
    endfunction

    function automatic logic [63:0] dec(input curve_point_t p);
        return p.x[63:0];
    endfunction

    function automatic curve_point_t ref_mult(input logic [SW-1:0] k, input logic [63:0] g);
        logic [63:0] kl;
        kl = k[63:0];
        return enc(kl * g);
    endfunction

    // Doublings after the leading one plus one add per further set bit.
    function automatic int ref_ops(input logic [SW-1:0] k);
        int t;
        t = 0;
        if (k == '0) return 0;
        for (int i = 0; i < int'(SW); i++) if (k[i]) t = i;
        return t + $countones(k) - 1;
    endfunction

    // One clock: sample around the edge, then play the add unit and stability monitor.
    task automatic step();
        logic fire, pend, rst_pre;
        curve_point_t pa, pb, rsp;
        fire    = add_req_valid && add_req_ready;
        pend    = add_req_valid && !add_req_ready;
        rst_pre = reset;
        pa      = add_op_a;
        pb      = add_op_b;
        if (start_valid && start_ready && !reset) start_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (add_req_valid) valid_cycles++;
        if (pend && !rst_pre) begin
            check_eq("req_hold_valid", CW'(add_req_valid), CW'(1));
            check_eq("req_hold_a", add_op_a, pa);
            check_eq("req_hold_b", add_op_b, pb);
        end
        if (fire) begin
            log_a.push_back(pa);
            log_b.push_back(pb);
            if (force_neg && pa == pb && pa == g_pt) rsp = enc(64'd0 - g_m);
            else                                      rsp = enc(dec(pa) + dec(pb));
            rsp_q.push_back(rsp);
            due_q.push_back(cyc + int'(LAT) - 1);
        end
        add_rsp_valid = 1'b0;
        add_rsp_point = enc(64'hDEAD_BEEF);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            add_rsp_valid = 1'b1;
            add_rsp_point = rsp_q.pop_front();
            void'(due_q.pop_front());
        end
        if (stall_cnt > 0) begin
            add_req_ready = 1'b0;
            if (add_req_valid) stall_cnt--;
        end else begin
            add_req_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start_job(input logic [SW-1:0] k, input curve_point_t p);
        logic taken;
        int n;
        taken = 1'b0;
        n = 0;
        log_a.delete();
        log_b.delete();
        valid_cycles = 0;
        scalar = k;
        point = p;
        start_valid = 1'b1;
        while (!taken && n < 100) begin
            taken = start_ready;
            step();
            n++;
        end
        if (!taken) check_eq("start_timeout", CW'(0), CW'(1));
        start_valid = 1'b0;
        scalar = SW'({$urandom, $urandom});
        point = enc({$urandom, $urandom});
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (!done_valid && n < 20000) begin
            step();
            n++;
        end
        if (!done_valid) check_eq("done_timeout", CW'(0), CW'(1));
        lat = cyc - start_cyc;
    endtask

    task automatic finish_done(input int hold);
        curve_point_t held;
        held = result;
        done_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_done_valid", CW'(done_valid), CW'(1));
            check_eq("hold_result", result, held);
            check_eq("hold_start_ready", CW'(start_ready), CW'(0));
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check_eq("post_done_valid", CW'(done_valid), CW'(0));
        check_eq("post_start_ready", CW'(start_ready), CW'(1));
        check_eq("post_busy", CW'(busy), CW'(0));
    endtask

    task automatic check_reset_state();
        check_eq("rst_start_ready", CW'(start_ready), CW'(1));
        check_eq("rst_done_valid", CW'(done_valid), CW'(0));
        check_eq("rst_req_valid", CW'(add_req_valid), CW'(0));
        check_eq("rst_busy", CW'(busy), CW'(0));
        check_eq("rst_result", result, inf_point);
        check_eq("rst_op_a", add_op_a, inf_point);
        check_eq("rst_op_b", add_op_b, inf_point);
        check_eq("rst_ops", CW'(ops_issued), CW'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [SW-1:0] k;
        logic [255:0] wide;

        reset = 1'b1;
        start_valid = 1'b0;
        scalar = '0;
        point = inf_point;
        done_ready = 1'b0;
        add_req_ready = 1'b0;
        add_rsp_valid = 1'b0;
        add_rsp_point = inf_point;
        g_m = {$urandom, $urandom} | 64'd1;
        g_pt = enc(g_m);

        repeat (3) step();
        check_reset_state();
        reset = 1'b0;
        step();

        // 1: zero scalar, no requests at all
        start_job(SW'(0), g_pt);
        wait_done(lat);
        check_eq("s1_latency", CW'(lat), CW'(1 + 3 * SW));
        check_eq("s1_result", result, inf_point);
        check_eq("s1_ops", CW'(ops_issued), CW'(0));
        check_eq("s1_no_req", CW'(valid_cycles), CW'(0));
        check_eq("s1_busy", CW'(busy), CW'(1));
        finish_done(0);

        // 2: scalar one just loads P
        start_job(SW'(1), g_pt);
        wait_done(lat);
        check_eq("s2_latency", CW'(lat), CW'(1 + 3 * SW));
        check_eq("s2_result", result, g_pt);
        check_eq("s2_ops", CW'(ops_issued), CW'(0));
        finish_done(1);

        // 3: scalar five, exact request sequence
        start_job(SW'(5), g_pt);
        wait_done(lat);
        check_eq("s3_nreq", CW'(log_a.size()), CW'(3));
        if (log_a.size() == 3) begin
            check_eq("s3_r0a", log_a[0], g_pt);
            check_eq("s3_r0b", log_b[0], g_pt);
            check_eq("s3_r1a", log_a[1], enc(2 * g_m));
            check_eq("s3_r1b", log_b[1], enc(2 * g_m));
            check_eq("s3_r2a", log_a[2], enc(4 * g_m));
            check_eq("s3_r2b", log_b[2], g_pt);
        end
        check_eq("s3_result", result, enc(5 * g_m));
        check_eq("s3_ops", CW'(ops_issued), CW'(3));
        finish_done(0);

        // 4: stalled first request, then backpressured result
        stall_cnt = 10;
        add_req_ready = 1'b0;
        start_job(SW'(2), g_pt);
        wait_done(lat);
        check_eq("s4_r0a", log_a.size() > 0 ? log_a[0] : inf_point, g_pt);
        check_eq("s4_r0b", log_b.size() > 0 ? log_b[0] : inf_point, g_pt);
        check_eq("s4_result", result, enc(2 * g_m));
        check_eq("s4_ops", CW'(ops_issued), CW'(1));
        finish_done(20);

        // 5: doubling forced to -G, so G + (-G) collapses to infinity
        force_neg = 1'b1;
        start_job(SW'(3), g_pt);
        wait_done(lat);
        force_neg = 1'b0;
        check_eq("s5_nreq", CW'(log_a.size()), CW'(2));
        if (log_a.size() == 2) begin
            check_eq("s5_r1a", log_a[1], enc(64'd0 - g_m));
            check_eq("s5_r1b", log_b[1], g_pt);
        end
        check_eq("s5_result", result, inf_point);
        check_eq("s5_ops", CW'(ops_issued), CW'(2));
        finish_done(0);

        // 6: reset while the final add of a scalar-five job is in flight
        start_job(SW'(5), g_pt);
        begin
            int n;
            n = 0;
            while (!(ops_issued == 10'd3 && !add_req_valid) && n < 2000) begin
                step();
                n++;
            end
            check_eq("s6_reach_wait", CW'(ops_issued), CW'(3));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state();
        start_job(SW'(1), g_pt);
        wait_done(lat);
        check_eq("s6_rsp_drained", CW'(due_q.size()), CW'(0));
        check_eq("s6_latency", CW'(lat), CW'(1 + 3 * SW));
        check_eq("s6_result", result, g_pt);
        check_eq("s6_ops", CW'(ops_issued), CW'(0));
        finish_done(0);

        // Random jobs against the group-arithmetic reference
        for (int j = 0; j < 5; j++) begin
            if (j == 4) begin
                for (int w = 0; w < 8; w++) wide[w*32 +: 32] = $urandom;
                k = SW'(wide);
            end else begin
                k = SW'({$urandom, $urandom} >> $urandom_range(0, 63));
            end
            g_m = {$urandom, $urandom} | 64'd1;
            g_pt = enc(g_m);
            start_job(k, g_pt);
            wait_done(lat);
            check_eq("rnd_result", result, ref_mult(k, g_m));
            check_eq("rnd_ops", CW'(ops_issued), CW'(ref_ops(k)));
            check_eq("rnd_min_latency", CW'(lat >= int'(1 + 3 * SW)), CW'(1));
            finish_done(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_mult_ctrl.md
# scalar_mult_ctrl

Double-and-add sequencer that computes k·P on the configured curve (BLS12-377 by default) by scheduling point doublings and additions onto one shared external point-add unit. It accepts a job (scalar and affine point) over a valid/ready handshake and walks the scalar MSB-first. It issues one add-unit request at a time, short-circuits operations involving the point at infinity, and returns the result over a second valid/ready handshake. It sits between the MSM bucket/job logic and the point-add datapath.

## Interface
- SCALAR_WIDTH, default elliptic_curve_structs::SCALAR_WIDTH (254), scalar bits processed per job
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  job offered
- start_ready  out  1  controller idle, job accepted on valid&ready
- scalar  in  SCALAR_WIDTH  k, sampled at start handshake
- point  in  curve_point_t  P, sampled at start handshake
- done_valid  out  1  result available
- done_ready  in  1  consumer accepts result
- result  out  curve_point_t  k·P; (0,0) encodes infinity
- add_req_valid  out  1  request to add unit
- add_req_ready  in  1  add unit accepts request
- add_op_a  out  curve_point_t  first operand
- add_op_b  out  curve_point_t  second operand; a==b means doubling
- add_rsp_valid  in  1  one-cycle response strobe, no backpressure
- add_rsp_point  in  curve_point_t  response sum
- ops_issued  out  10  requests accepted by add unit in current/last job
- busy  out  1  state != IDLE

## Operation
- Infinity is encoded as inf_point (0,0), which is not on the curve (b=1). Define acc_inf = (acc.x==0 && acc.y==0).
- States: IDLE, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT, DONE.
- IDLE: start_ready=1. On handshake: latch scalar and point, set acc=inf, idx=SCALAR_WIDTH-1, ops_issued=0, go DBL.
- DBL: if acc_inf, go ADD with no request. Otherwise drive add_req_valid with a=b=acc. On add_req_ready: ops_issued+1, go DBL_WAIT.
- DBL_WAIT: on add_rsp_valid: acc=add_rsp_point, go ADD.
- ADD: if scalar[idx]==0, go NEXT. Else if acc_inf, set acc=P and go NEXT with no request. Else drive a=acc, b=P. On add_req_ready: ops_issued+1, go ADD_WAIT.
- ADD_WAIT: on add_rsp_valid: acc=add_rsp_point, go NEXT. A response equal to (0,0) is legal and sets acc_inf.
- NEXT: if idx==0, go DONE. Else idx-1, go DBL.
- DONE: done_valid=1, result=acc. On done_ready, go IDLE.
- add_rsp_valid outside the WAIT states is ignored.
- Once add_req_valid rises, it and the operands are held stable until add_req_ready.
- result holds stable while done_valid && !done_ready.
- idx width: $clog2(SCALAR_WIDTH).

## Timing
- Reset values: state IDLE, start_ready=1 (IDLE), done_valid=0, add_req_valid=0, busy=0, result=(0,0), add_op_a/b=(0,0), ops_issued=0, acc=(0,0).
- Reset mid-job aborts immediately. A response arriving after reset is ignored.
- Start handshake at cycle 0 puts the controller in DBL at cycle 1.
- A skipped bit costs exactly 3 cycles (DBL, ADD, NEXT).
- Each issued operation adds (cycles waiting for ready) plus (response latency) plus 1.
- With zero issued operations, done_valid asserts at cycle 1+3·SCALAR_WIDTH (763 for 254).
- start_ready=0 in every state except IDLE.
- A new job can be accepted no earlier than the cycle after the done handshake.

## Structure
- elliptic_curve_structs keeps curve_point_t, inf_point, SCALAR_WIDTH and P_WIDTH.
- Add a package function is_inf(curve_point_t) so the add unit and other blocks share one infinity test.
- The state enum stays local to the module.
- No sub-module. The point-add unit is external and attached through the add_* ports.

## Test plan
Each scenario runs against an add-unit model with 5-cycle response latency and randomized add_req_ready.
1. scalar=0, point=G → done_valid at cycle 763, result=(0,0), ops_issued=0, add_req_valid never asserted.
2. scalar=1, point=G → done_valid at cycle 763, result=G, ops_issued=0.
3. scalar=5, point=G → request sequence exactly (G,G), (2G,2G), (4G,G); result=5G per the model; ops_issued=3.
4. scalar=2, add_req_ready low for 10 cycles on the first request → add_req_valid and operands (G,G) stable throughout; result=2G. Then hold done_ready low for 20 cycles → done_valid and result stable, start_ready=0.
5. Model returns (0,0) for G+(-G): scalar=3, point with doubling response forced to -G → acc becomes infinity; no further requests; result=(0,0).
6. Assert reset during ADD_WAIT of a scalar=5 job, then deliver add_rsp_valid → outputs at reset values, response ignored; a following scalar=1 job returns G at cycle 763.
